// File: rtl/flag_round_judge_if.sv
// Bus between the FlagUPDOWN register slave (master side) and the game core
// (slave side).
//   master drives : rom_we/rom_addr/rom_wdata, start, abort, cfg_len, cfg_window,
//                   pose_valid/pose (detector strobe routed through the slave)
//   master reads  : cmd_valid/cmd_out, result_valid/result_hit, score,
//                   round_idx, busy, done
interface flag_round_judge_if #(
   parameter int ROM_DEPTH = 16,
   parameter int ADDR_W    = $clog2(ROM_DEPTH),
   parameter int WIN_W     = 16,
   parameter int SCORE_W   = $clog2(ROM_DEPTH + 1)
);
   logic               rom_we;
   logic [ADDR_W-1:0]  rom_addr;
   logic [1:0]         rom_wdata;
   logic               start;
   logic               abort;
   logic [SCORE_W-1:0] cfg_len;
   logic [WIN_W-1:0]   cfg_window;
   logic               pose_valid;
   logic [1:0]         pose;
   logic               cmd_valid;
   logic [1:0]         cmd_out;
   logic               result_valid;
   logic               result_hit;
   logic [SCORE_W-1:0] score;
   logic [ADDR_W-1:0]  round_idx;
   logic               busy;
   logic               done;

   modport master (
      output rom_we, rom_addr, rom_wdata, start, abort, cfg_len, cfg_window,
             pose_valid, pose,
      input  cmd_valid, cmd_out, result_valid, result_hit, score, round_idx,
             busy, done
   );

   modport slave (
      input  rom_we, rom_addr, rom_wdata, start, abort, cfg_len, cfg_window,
             pose_valid, pose,
      output cmd_valid, cmd_out, result_valid, result_hit, score, round_idx,
             busy, done
   );
endinterface

// File: rtl/flag_round_judge.sv
// Flag up/down game core. Plays cfg_len commands from a small command ROM,
// presents each one, and judges the pose detector's answer inside a window of
// cfg_window cycles (0 treated as 1).
//   ACLK    : clock, everything on the rising edge
//   ARESETN : asynchronous active-low reset (ROM contents are kept)
//   bus     : flag_round_judge_if.slave -- ROM write port, start/abort pulses,
//             config, pose input; command, result, score and status outputs
module flag_round_judge #(
   parameter int ROM_DEPTH = 16,
   parameter int ADDR_W    = $clog2(ROM_DEPTH),
   parameter int WIN_W     = 16,
   parameter int SCORE_W   = $clog2(ROM_DEPTH + 1)
) (
   input logic               ACLK,
   input logic               ARESETN,
   flag_round_judge_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

   state_t             state_q;
   logic [1:0]         rom_q [ROM_DEPTH];
   logic [SCORE_W-1:0] len_q;
   logic [WIN_W-1:0]   win_q;
   logic [WIN_W-1:0]   timer_q;
   logic [ADDR_W-1:0]  idx_q;

   logic               cmd_valid_q;
   logic [1:0]         cmd_out_q;
   logic               result_valid_q;
   logic               result_hit_q;
   logic [SCORE_W-1:0] score_q;
   logic [ADDR_W-1:0]  round_idx_q;
   logic               busy_q;
   logic               done_q;

   logic               start_ok_d;
   logic               hit_d;
   logic               last_d;
   logic [WIN_W-1:0]   win_d;

   // Out-of-range lengths are dropped silently; abort beats a same-cycle start.
   assign start_ok_d = bus.start && !bus.abort && (bus.cfg_len != '0) &&
                       (bus.cfg_len <= SCORE_W'(ROM_DEPTH));
   // Mismatching poses are just intermediate motion, never a miss.
   assign hit_d      = bus.pose_valid && (bus.pose == cmd_out_q);
   // idx widened by one bit so idx+1 == ROM_DEPTH is representable.
   assign last_d     = (SCORE_W'(idx_q) + SCORE_W'(1)) == len_q;
   assign win_d      = (bus.cfg_window == '0) ? WIN_W'(1) : bus.cfg_window;

   // Command ROM: writable only while idle, not reset.
   always_ff @(posedge ACLK) begin
      if (bus.rom_we && (state_q == S_IDLE))
         rom_q[bus.rom_addr] <= bus.rom_wdata;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q        <= S_IDLE;
         len_q          <= '0;
         win_q          <= '0;
         timer_q        <= '0;
         idx_q          <= '0;
         cmd_valid_q    <= 1'b0;
         cmd_out_q      <= '0;
         result_valid_q <= 1'b0;
         result_hit_q   <= 1'b0;
         score_q        <= '0;
         round_idx_q    <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         cmd_valid_q    <= 1'b0;
         result_valid_q <= 1'b0;
         done_q         <= 1'b0;
         if (bus.abort) begin
            // score, round_idx and cmd_out keep their values for read-back
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_ok_d) begin
                     len_q        <= bus.cfg_len;
                     win_q        <= win_d;
                     idx_q        <= '0;
                     score_q      <= '0;
                     result_hit_q <= 1'b0;
                     busy_q       <= 1'b1;
                     state_q      <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  cmd_out_q   <= rom_q[idx_q];
                  round_idx_q <= idx_q;
                  cmd_valid_q <= 1'b1;
                  timer_q     <= win_q;
                  state_q     <= S_WAIT;
               end
               S_WAIT: begin
                  // hit checked first so it wins on the last window cycle
                  if (hit_d) begin
                     score_q        <= score_q + SCORE_W'(1);
                     result_hit_q   <= 1'b1;
                     result_valid_q <= 1'b1;
                     state_q        <= S_NEXT;
                  end else if (timer_q == WIN_W'(1)) begin
                     result_hit_q   <= 1'b0;
                     result_valid_q <= 1'b1;
                     state_q        <= S_NEXT;
                  end else begin
                     timer_q <= timer_q - WIN_W'(1);
                  end
               end
               S_NEXT: begin
                  if (last_d) begin
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q + ADDR_W'(1);
                     state_q <= S_ISSUE;
                  end
               end
               S_DONE: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.cmd_valid    = cmd_valid_q;
   assign bus.cmd_out      = cmd_out_q;
   assign bus.result_valid = result_valid_q;
   assign bus.result_hit   = result_hit_q;
   assign bus.score        = score_q;
   assign bus.round_idx    = round_idx_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
endmodule
